// File: rtl/axis_block_arbiter.sv
// axis_block_arbiter
//   Round-robin, whole-block arbiter that shares one downstream AXIS processing
//   element among NUM_INPUTS AXIS producers. A granted source owns the output
//   for exactly 2**BLOCK_SIZE_LOG handshakes. Only then is the grant released.
//   Arbitration is registered, so there is one idle (bubble) cycle between bursts.
//
// Ports
//   clk            in   1                      rising-edge clock
//   rst            in   1                      asynchronous, active-high reset
//   input_valid    in   NUM_INPUTS             per-source valid (bit i = source i)
//   input_ready    out  NUM_INPUTS             per-source ready
//   input_data     in   NUM_INPUTS*DATA_WIDTH  source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   output_valid   out  1                      to the shared element
//   output_ready   in   1                      from the shared element
//   output_data    out  DATA_WIDTH             sample of the granted source
//   output_source  out  SRC_WIDTH              index of the granted source
//   output_last    out  1                      final transfer of a block
//                                              (only with AXIS_BLOCK_ARBITER_LAST_EN)
//
// Build option
//   AXIS_BLOCK_ARBITER_LAST_EN : when defined, adds output_last.

module axis_block_arbiter #(
    parameter int  NUM_INPUTS     = 2,
    parameter int  DATA_WIDTH     = 16,
    parameter int  BLOCK_SIZE_LOG = 8,
    localparam int SRC_WIDTH      = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS-1:0]            input_valid,
    output logic [NUM_INPUTS-1:0]            input_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] input_data,
    output logic                             output_valid,
    input  logic                             output_ready,
    output logic [DATA_WIDTH-1:0]            output_data,
`ifdef AXIS_BLOCK_ARBITER_LAST_EN
    output logic [SRC_WIDTH-1:0]             output_source,
    output logic                             output_last
`else
    output logic [SRC_WIDTH-1:0]             output_source
`endif
);

    // A one-transfer block (BLOCK_SIZE_LOG=0) keeps a 1-bit counter pinned at 0.
    localparam int CNT_WIDTH  = (BLOCK_SIZE_LOG > 0) ? BLOCK_SIZE_LOG : 1;
    localparam int BLOCK_LAST = (1 << BLOCK_SIZE_LOG) - 1;

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SRC_WIDTH-1:0]   r_grant;
    logic [SRC_WIDTH-1:0]   r_last_grant;
    logic [CNT_WIDTH-1:0]   r_count;

    logic                   w_hi_found;
    logic [SRC_WIDTH-1:0]   w_hi_pick;
    logic                   w_lo_found;
    logic [SRC_WIDTH-1:0]   w_lo_pick;
    logic                   w_pick_found;
    logic [SRC_WIDTH-1:0]   w_pick;
    logic                   w_sel_valid;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_handshake;
    logic                   w_block_end;

    // Rotating scan starting at last_grant+1: the lowest valid index above
    // last_grant wins. If there is none, the scan wraps and the lowest valid
    // index overall wins.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_pick  = '0;
        w_lo_found = 1'b0;
        w_lo_pick  = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (input_valid[i]) begin
                if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_pick  = SRC_WIDTH'(i);
                end
                if (!w_hi_found && (SRC_WIDTH'(i) > r_last_grant)) begin
                    w_hi_found = 1'b1;
                    w_hi_pick  = SRC_WIDTH'(i);
                end
            end
        end
        w_pick_found = w_lo_found;
        w_pick       = w_hi_found ? w_hi_pick : w_lo_pick;
    end

    // Select the granted source.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (SRC_WIDTH'(i) == r_grant) begin
                w_sel_valid = input_valid[i];
                w_sel_data  = input_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_block_end = (r_count == CNT_WIDTH'(BLOCK_LAST));

    // Next-state logic and outputs.
    always_comb begin
        w_state_next = r_state;
        output_valid = 1'b0;
        input_ready  = '0;
        output_data  = '0;
        w_handshake  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                output_valid = w_sel_valid;
                output_data  = w_sel_data;
                for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                    if (SRC_WIDTH'(i) == r_grant) begin
                        input_ready[i] = output_ready;
                    end
                end
                w_handshake = w_sel_valid & output_ready;
                if (w_handshake && w_block_end) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // output_source also holds the last grant while the arbiter is idle.
    assign output_source = r_grant;

`ifdef AXIS_BLOCK_ARBITER_LAST_EN
    assign output_last = (r_state == S_BURST) && w_block_end;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= SRC_WIDTH'(NUM_INPUTS - 1);
            r_count      <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_pick_found) begin
                r_grant <= w_pick;
            end
            if (w_handshake) begin
                if (w_block_end) begin
                    r_count      <= '0;
                    r_last_grant <= r_grant;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_block_arbiter.sv
// tb_axis_block_arbiter
//   Self-checking bench for axis_block_arbiter with NUM_INPUTS=3 and
//   BLOCK_SIZE_LOG=2. It uses a directed vector table, hand-written
//   round-robin and asynchronous-reset sequences, and randomized traffic.
//   The randomized traffic is compared against a behavioural model of the
//   grant and block rules. Inputs are driven 1 time unit after the rising
//   edge, and outputs are sampled near the falling edge.

module tb_axis_block_arbiter;

    localparam int N   = 3;
    localparam int DW  = 16;
    localparam int BSL = 2;
    localparam int BLK = 1 << BSL;
    localparam int SW  = (N > 2) ? $clog2(N) : 1;

    logic              clk;
    logic              rst;
    logic [N-1:0]      input_valid;
    logic [N-1:0]      input_ready;
    logic [N*DW-1:0]   input_data;
    logic              output_valid;
    logic              output_ready;
    logic [DW-1:0]     output_data;
    logic [SW-1:0]     output_source;
`ifdef AXIS_BLOCK_ARBITER_LAST_EN
    logic              output_last;
`endif

    axis_block_arbiter #(
        .NUM_INPUTS    (N),
        .DATA_WIDTH    (DW),
        .BLOCK_SIZE_LOG(BSL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
`ifdef AXIS_BLOCK_ARBITER_LAST_EN
        .output_source(output_source),
        .output_last  (output_last)
`else
        .output_source(output_source)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit            m_busy;
    logic [SW-1:0] m_grant;
    logic [SW-1:0] m_last;
    int            m_cnt;

    int hs_src[$];

    typedef struct {
        logic [N-1:0] valid;
        logic         ready;
        bit           eb;     // expected: a source owns the output
        bit           ev;
        logic [N-1:0] er;
        int           es;
        bit           el;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [DW-1:0] dsel(input int s);
        return input_data[s*DW +: DW];
    endfunction

    task automatic check(input string name, input bit eb, input bit ev,
                         input logic [N-1:0] er, input int es, input bit el);
        logic [DW-1:0] ed;
        bit            bad;
        ed  = eb ? dsel(es) : '0;
        bad = (output_valid !== ev) || (input_ready !== er) ||
              (output_data !== ed) || (output_source !== SW'(es));
`ifdef AXIS_BLOCK_ARBITER_LAST_EN
        bad = bad || (output_last !== el);
`endif
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL %s: got valid=%0b ready=%b data=%h src=%0d, want valid=%0b ready=%b data=%h src=%0d last=%0b",
                     name, output_valid, input_ready, output_data, output_source,
                     ev, er, ed, es, el);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_grant = '0;
        m_last  = SW'(N - 1);
        m_cnt   = 0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        input_valid  = '0;
        output_ready = 1'b0;
        input_data   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // This task is called 1 time unit after a rising edge, with the inputs
    // already driven. It checks the outputs against the model, then advances
    // the model across the next edge.
    task automatic model_step(input string name);
        bit           ev;
        logic [N-1:0] er;
        bit           el;
        bit           found;
        int           s;
        #4;
        ev = m_busy && input_valid[m_grant];
        er = '0;
        if (m_busy) er[m_grant] = output_ready;
        el = m_busy && (m_cnt == BLK - 1);
        check(name, m_busy, ev, er, int'(m_grant), el);
        if (output_valid && output_ready) hs_src.push_back(int'(output_source));
        @(posedge clk);
        if (m_busy) begin
            if (ev && output_ready) begin
                m_cnt++;
                if (m_cnt == BLK) begin
                    m_cnt  = 0;
                    m_last = m_grant;
                    m_busy = 1'b0;
                end
            end
        end else begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                s = (int'(m_last) + k) % N;
                if (!found && input_valid[SW'(s)]) begin
                    found   = 1'b1;
                    m_grant = SW'(s);
                    m_busy  = 1'b1;
                end
            end
        end
        #1;
    endtask

    initial begin
        int nchk;

        // Directed table. The sequence starts from reset, and data is
        // randomized on every step.
        tbl[0] = '{3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 0, 1'b0};
        tbl[1] = '{3'b010, 1'b1, 1'b0, 1'b0, 3'b000, 0, 1'b0};
        tbl[2] = '{3'b011, 1'b1, 1'b1, 1'b1, 3'b010, 1, 1'b0};
        tbl[3] = '{3'b011, 1'b1, 1'b1, 1'b1, 3'b010, 1, 1'b0};
        tbl[4] = '{3'b001, 1'b1, 1'b1, 1'b0, 3'b010, 1, 1'b0};
        tbl[5] = '{3'b011, 1'b0, 1'b1, 1'b1, 3'b000, 1, 1'b0};
        tbl[6] = '{3'b011, 1'b1, 1'b1, 1'b1, 3'b010, 1, 1'b0};
        tbl[7] = '{3'b011, 1'b1, 1'b1, 1'b1, 3'b010, 1, 1'b1};
        tbl[8] = '{3'b011, 1'b1, 1'b0, 1'b0, 3'b000, 1, 1'b0};
        tbl[9] = '{3'b011, 1'b1, 1'b1, 1'b1, 3'b001, 0, 1'b0};

        do_reset();
        #1 check("reset", 1'b0, 1'b0, '0, 0, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            input_valid  = tbl[i].valid;
            output_ready = tbl[i].ready;
            input_data   = (N*DW)'({$urandom(), $urandom()});
            #4;
            check($sformatf("tbl%0d", i), tbl[i].eb, tbl[i].ev, tbl[i].er,
                  tbl[i].es, tbl[i].el);
            @(posedge clk); #1;
        end

        // Round-robin: all sources are continuously valid, with no back-pressure.
        do_reset();
        hs_src.delete();
        input_valid  = '1;
        output_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            input_data = (N*DW)'({$urandom(), $urandom()});
            model_step("rr");
        end
        n_vec++;
        if (hs_src.size() < 24) begin
            n_err++;
            $display("FAIL rr_count: got %0d handshakes, want at least 24", hs_src.size());
        end
        nchk = (hs_src.size() < 24) ? hs_src.size() : 24;
        for (int k = 0; k < nchk; k++) begin
            n_vec++;
            if (hs_src[k] != (k / BLK) % N) begin
                n_err++;
                $display("FAIL rr_order[%0d]: got src %0d, want %0d", k, hs_src[k], (k / BLK) % N);
            end
        end

        // Asynchronous reset after 3 of the 4 transfers of a burst.
        do_reset();
        input_valid  = 3'b001;
        output_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            input_data = (N*DW)'({$urandom(), $urandom()});
            model_step("pre_rst");
        end
        #2 rst = 1'b1;
        #1 check("async_rst", 1'b0, 1'b0, '0, 0, 1'b0);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 12; i++) begin
            input_data = (N*DW)'({$urandom(), $urandom()});
            model_step("post_rst");
        end

        // Randomized traffic with stalls on both sides.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < N; b++) input_valid[b] = ($urandom_range(0, 3) != 0);
            output_ready = ($urandom_range(0, 9) < 7);
            input_data   = (N*DW)'({$urandom(), $urandom()});
            model_step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
